// File: rtl/icache_pipelined_lookup.sv
// VIPT set-associative icache: 2-stage lookup, blocking L2 miss FSM, tree-PLRU, sequential flush.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_COUNTERS_EN.
module icache_pipelined_lookup #(
   parameter int ICACHE_SIZE        = 8192,
   parameter int ICACHE_BLOCK_SIZE  = 32,
   parameter int ICACHE_ASSOC       = 2,
   parameter int ICACHE_FETCH_WIDTH = 16,
   parameter int PA_WIDTH           = 34,
   localparam int OFF_W    = $clog2(ICACHE_BLOCK_SIZE),
   localparam int NUM_SETS = ICACHE_SIZE / ICACHE_ASSOC / ICACHE_BLOCK_SIZE,
   localparam int IDX_W    = $clog2(NUM_SETS),
   localparam int TAG_W    = PA_WIDTH - IDX_W - OFF_W,
   localparam int FOFF_W   = $clog2(ICACHE_BLOCK_SIZE / ICACHE_FETCH_WIDTH),
   localparam int FOFF_PW  = (FOFF_W > 0) ? FOFF_W : 1
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            fetch_req_valid,
   output logic                            fetch_req_ready,
   input  logic [IDX_W-1:0]                fetch_req_index,
   input  logic [FOFF_PW-1:0]              fetch_req_foff,
   input  logic                            tlb_resp_valid,
   input  logic [TAG_W-1:0]                tlb_resp_tag,
   output logic                            fetch_resp_valid,
   output logic                            fetch_resp_hit,
   output logic [ICACHE_FETCH_WIDTH*8-1:0] fetch_resp_instrs,
   output logic                            l2_req_valid,
   input  logic                            l2_req_ready,
   output logic [TAG_W+IDX_W-1:0]          l2_req_block_addr,
   input  logic                            l2_resp_valid,
   input  logic [ICACHE_BLOCK_SIZE*8-1:0]  l2_resp_data,
   input  logic                            flush_valid,
   output logic                            flush_done
`ifdef ICACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]                     perf_hits,
   output logic [31:0]                     perf_misses
`endif
);

   localparam int BLK_BITS   = ICACHE_BLOCK_SIZE * 8;
   localparam int FETCH_BITS = ICACHE_FETCH_WIDTH * 8;
   localparam int WAY_W      = (ICACHE_ASSOC > 1) ? $clog2(ICACHE_ASSOC) : 1;
   localparam int LVLS       = $clog2(ICACHE_ASSOC);
   localparam int PLRU_W     = (ICACHE_ASSOC > 1) ? ICACHE_ASSOC - 1 : 1;

   // Index plus offset must fit in the 4 KB page so the index is untranslated.
   generate
      if (IDX_W + OFF_W > 12) begin : g_geom_err
         $error("icache index+offset exceeds page offset bits");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic                   flush_pend_q, flush_pend_d;
   logic [IDX_W-1:0]       flush_cnt_q, flush_cnt_d;
   logic [TAG_W+IDX_W-1:0] miss_addr_q, miss_addr_d;
   logic                   s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]       s1_idx_q, s1_idx_d;
   logic [FOFF_PW-1:0]     s1_foff_q, s1_foff_d;
   logic [ICACHE_ASSOC-1:0] valid_q [NUM_SETS];
   logic [ICACHE_ASSOC-1:0] valid_d [NUM_SETS];
   logic [PLRU_W-1:0]      plru_q [NUM_SETS];
   logic [PLRU_W-1:0]      plru_d [NUM_SETS];

   logic [TAG_W-1:0]       tag_mem  [ICACHE_ASSOC][NUM_SETS];
   logic [BLK_BITS-1:0]    data_mem [ICACHE_ASSOC][NUM_SETS];
   logic [TAG_W-1:0]       tag_rd   [ICACHE_ASSOC];
   logic [BLK_BITS-1:0]    data_rd  [ICACHE_ASSOC];

   logic                    accept, lookup, resp_ok, hit, fill_en;
   logic [ICACHE_ASSOC-1:0] hit_vec, miss_valid;
   logic [WAY_W-1:0]        hit_way, fill_way;
   logic [IDX_W-1:0]        miss_idx;
   logic [TAG_W-1:0]        miss_tag;
   logic [BLK_BITS-1:0]     hit_block;

   // Tree walk: each node bit points at the subtree holding the victim (1 = right).
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      logic [PLRU_W-1:0] t;
      int node;
      node = 1;
      for (int l = 0; l < LVLS; l++) begin
         t    = bits >> (node - 1);
         node = 2 * node + int'(t[0]);
      end
      return WAY_W'(node - ICACHE_ASSOC);
   endfunction

   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0]  way);
      logic [PLRU_W-1:0] res, mask;
      logic [WAY_W-1:0]  w;
      int node;
      res  = bits;
      node = 1;
      for (int l = 0; l < LVLS; l++) begin
         w    = way >> (LVLS - 1 - l);
         mask = PLRU_W'(1) << (node - 1);
         res  = w[0] ? (res & ~mask) : (res | mask);
         node = 2 * node + int'(w[0]);
      end
      return res;
   endfunction

   assign fetch_req_ready   = (state_q == IDLE);
   assign accept            = fetch_req_valid & fetch_req_ready;
   assign miss_idx          = miss_addr_q[IDX_W-1:0];
   assign miss_tag          = miss_addr_q[IDX_W +: TAG_W];
   assign l2_req_valid      = (state_q == MISS_REQ);
   assign l2_req_block_addr = miss_addr_q;

   always_comb begin
      hit_vec    = '0;
      hit_way    = '0;
      miss_valid = valid_q[miss_idx];
      fill_way   = plru_victim(plru_q[miss_idx]);
      for (int w = 0; w < ICACHE_ASSOC; w++) begin
         hit_vec[w] = valid_q[s1_idx_q][w] & (tag_rd[w] == tlb_resp_tag);
      end
      for (int w = ICACHE_ASSOC - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (!miss_valid[w]) fill_way = WAY_W'(w);
      end
      hit       = |hit_vec;
      hit_block = data_rd[hit_way];
   end

   // A flush accepted in IDLE kills the same-cycle stage-1 lookup and outranks its miss.
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      flush_cnt_d  = flush_cnt_q;
      miss_addr_d  = miss_addr_q;
      valid_d      = valid_q;
      plru_d       = plru_q;
      fill_en      = 1'b0;
      flush_done   = 1'b0;
      s1_valid_d   = accept;
      s1_idx_d     = accept ? fetch_req_index : s1_idx_q;
      s1_foff_d    = accept ? fetch_req_foff : s1_foff_q;

      lookup            = s1_valid_q & tlb_resp_valid;
      resp_ok           = lookup & (state_q == IDLE) & ~flush_valid;
      fetch_resp_valid  = resp_ok;
      fetch_resp_hit    = resp_ok & hit;
      fetch_resp_instrs = (resp_ok & hit) ?
                          hit_block[int'(s1_foff_q) * FETCH_BITS +: FETCH_BITS] : '0;

      if (resp_ok & hit & (ICACHE_ASSOC > 1)) begin
         plru_d[s1_idx_q] = plru_touch(plru_q[s1_idx_q], hit_way);
      end

      case (state_q)
         IDLE: begin
            if (flush_valid) begin
               state_d     = FLUSH;
               flush_cnt_d = '0;
            end else if (lookup & ~hit) begin
               state_d     = MISS_REQ;
               miss_addr_d = {tlb_resp_tag, s1_idx_q};
            end
         end
         MISS_REQ: begin
            if (flush_valid) flush_pend_d = 1'b1;
            if (l2_req_ready) state_d = MISS_WAIT;
         end
         MISS_WAIT: begin
            if (flush_valid) flush_pend_d = 1'b1;
            if (l2_resp_valid) begin
               fill_en                     = 1'b1;
               valid_d[miss_idx][fill_way] = 1'b1;
               if (ICACHE_ASSOC > 1) plru_d[miss_idx] = plru_touch(plru_q[miss_idx], fill_way);
               flush_pend_d = 1'b0;
               flush_cnt_d  = '0;
               state_d      = (flush_pend_q | flush_valid) ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            valid_d[flush_cnt_q] = '0;
            if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) begin
               flush_done = 1'b1;
               state_d    = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         flush_pend_q <= 1'b0;
         flush_cnt_q  <= '0;
         miss_addr_q  <= '0;
         s1_valid_q   <= 1'b0;
         s1_idx_q     <= '0;
         s1_foff_q    <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         flush_cnt_q  <= flush_cnt_d;
         miss_addr_q  <= miss_addr_d;
         s1_valid_q   <= s1_valid_d;
         s1_idx_q     <= s1_idx_d;
         s1_foff_q    <= s1_foff_d;
         valid_q      <= valid_d;
         plru_q       <= plru_d;
      end
   end

   // Tag/data arrays are plain synchronous RAMs with no reset.
   always_ff @(posedge CLK) begin
      if (fill_en) begin
         tag_mem[fill_way][miss_idx]  <= miss_tag;
         data_mem[fill_way][miss_idx] <= l2_resp_data;
      end
      if (accept) begin
         for (int w = 0; w < ICACHE_ASSOC; w++) begin
            tag_rd[w]  <= tag_mem[w][fetch_req_index];
            data_rd[w] <= data_mem[w][fetch_req_index];
         end
      end
   end

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;

   always_comb begin
      perf_hits_d   = perf_hits_q;
      perf_misses_d = perf_misses_q;
      if (resp_ok & hit & ~&perf_hits_q) perf_hits_d = perf_hits_q + 32'd1;
      if (resp_ok & ~hit & ~&perf_misses_q) perf_misses_d = perf_misses_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
      end else begin
         perf_hits_q   <= perf_hits_d;
         perf_misses_q <= perf_misses_d;
      end
   end

   assign perf_hits   = perf_hits_q;
   assign perf_misses = perf_misses_q;
`endif

endmodule
